// File: rtl/uart_tx_param_if.sv
// Producer-side handshake for uart_tx_param: a DATA_BITS word qualified by valid/ready.
// The producer drives through the master modport and the transmitter through the slave modport.
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Optional line break generation is enabled by defining UART_TX_BREAK_EN (adds send_break).
module uart_tx_param #(
    parameter int unsigned CLOCK_FREQ = 125000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  sysclk,
    input  logic                  rst,
    uart_tx_param_if.slave        in_if,
`ifdef UART_TX_BREAK_EN
    input  logic                  send_break,
`endif
    output logic                  busy,
    output logic                  serial_out
);

    localparam int unsigned CyclesPerBit = (BAUD_RATE == 0) ? 0 : CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CntW         = (CyclesPerBit > 2) ? $clog2(CyclesPerBit) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        CyclesPerBit < 2) begin : g_param_check
        $error("uart_tx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 bit_done;
    logic                 break_hold;
    logic                 accept;

`ifdef UART_TX_BREAK_EN
    // brk_q stays set from break assertion until the mark-after-break bit time has elapsed.
    logic                 brk_q, brk_d;
    assign break_hold = send_break | brk_q;
`else
    assign break_hold = 1'b0;
`endif

    assign bit_done            = (cnt_q == CntW'(CyclesPerBit - 1));
    assign in_if.data_in_ready = (state_q == StIdle) && !break_hold;
    assign accept              = in_if.data_in_valid && in_if.data_in_ready;
    assign busy                = (state_q != StIdle);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
`ifdef UART_TX_BREAK_EN
            brk_q   <= brk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_done ? '0 : cnt_q + CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
`ifdef UART_TX_BREAK_EN
        brk_d   = brk_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
`ifdef UART_TX_BREAK_EN
                if (send_break) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    if (bit_done) begin
                        brk_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`endif
                if (accept) begin
                    state_d = StStart;
                    shift_d = in_if.data_in;
                    // Even parity is the XOR of the word; odd parity is its inverse.
                    par_d   = (^in_if.data_in) ^ (PARITY == 1);
                    idx_d   = '0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? StParity : StStop;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    idx_d   = '0;
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (idx_q == 4'(STOP_BITS - 1)) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        serial_out = 1'b1;
        case (state_q)
`ifdef UART_TX_BREAK_EN
            StIdle:   serial_out = ~send_break;
`else
            StIdle:   serial_out = 1'b1;
`endif
            StStart:  serial_out = 1'b0;
            StData:   serial_out = shift_q[0];
            StParity: serial_out = par_q;
            StStop:   serial_out = 1'b1;
            default:  serial_out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: several parameter sets, per-bit line checks on each frame.
// Break generation is exercised only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

    localparam int unsigned NI = 5;
    localparam int unsigned CF  [NI] = '{10, 10, 10, 10, 5};
    localparam int unsigned BR  [NI] = '{1, 1, 1, 1, 2};
    localparam int unsigned DB  [NI] = '{8, 8, 8, 7, 9};
    localparam int unsigned PA  [NI] = '{0, 2, 1, 2, 1};
    localparam int unsigned SB  [NI] = '{1, 1, 1, 2, 2};
    localparam int unsigned CPB [NI] = '{10, 10, 10, 10, 2};

    logic          sysclk;
    logic          rst;
    logic [8:0]    data_v [NI];
    logic [NI-1:0] valid_v;
    logic [NI-1:0] rdy_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] so_v;
`ifdef UART_TX_BREAK_EN
    logic [NI-1:0] brk_v;
`endif

    int  checks;
    int  errors;
    int  sel;
    bit  exp_q[$];
    longint acc_t;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_param_if #(.DATA_BITS(DB[g])) bus ();
        assign bus.data_in       = data_v[g][DB[g]-1:0];
        assign bus.data_in_valid = valid_v[g];
        assign rdy_v[g]          = bus.data_in_ready;

        uart_tx_param #(
            .CLOCK_FREQ(CF[g]),
            .BAUD_RATE (BR[g]),
            .DATA_BITS (DB[g]),
            .PARITY    (PA[g]),
            .STOP_BITS (SB[g])
        ) dut (
            .sysclk    (sysclk),
            .rst       (rst),
            .in_if     (bus),
`ifdef UART_TX_BREAK_EN
            .send_break(brk_v[g]),
`endif
            .busy      (busy_v[g]),
            .serial_out(so_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected line levels of one frame, one entry per bit time.
    function automatic void push_frame(input int i, input logic [8:0] w);
        bit p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int b = 0; b < int'(DB[i]); b++) begin
            exp_q.push_back(w[b]);
            p = p ^ w[b];
        end
        if (PA[i] != 0) exp_q.push_back((PA[i] == 1) ? ~p : p);
        for (int s = 0; s < int'(SB[i]); s++) exp_q.push_back(1'b1);
    endfunction

    always @(posedge sysclk) begin
        if (!rst && valid_v[sel] && rdy_v[sel]) begin
            push_frame(sel, data_v[sel]);
            acc_t <= longint'($time);
        end
    end

    task automatic check_frames(input int i, input int n, input int exp_gap);
        int  waited;
        int  nb;
        int  good;
        bit  lvl;
        nb = 1 + int'(DB[i]) + ((PA[i] != 0) ? 1 : 0) + int'(SB[i]);
        for (int f = 0; f < n; f++) begin
            waited = 0;
            @(negedge sysclk);
            while (so_v[i] !== 1'b0 && waited < 300) begin
                waited++;
                @(negedge sysclk);
            end
            if (waited >= 300) begin
                check($sformatf("i%0d f%0d start_timeout", i, f), 0, 1);
                return;
            end
            check($sformatf("i%0d f%0d latency", i, f), 32'(longint'($time) - acc_t), 5);
            if (f > 0 && exp_gap >= 0) check($sformatf("i%0d gap", i), waited + 1, exp_gap);
            for (int b = 0; b < nb; b++) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("i%0d f%0d queue_empty", i, f), 0, 1);
                    return;
                end
                lvl  = exp_q.pop_front();
                good = 0;
                for (int c = 0; c < int'(CPB[i]); c++) begin
                    if (b > 0 || c > 0) @(negedge sysclk);
                    if (so_v[i] === lvl && busy_v[i] === 1'b1 && rdy_v[i] === 1'b0) good++;
                end
                check($sformatf("i%0d f%0d bit%0d", i, f, b), good, CPB[i]);
            end
            @(negedge sysclk);
            check($sformatf("i%0d f%0d idle_after", i, f), {so_v[i], busy_v[i], rdy_v[i]},
                  3'b101);
        end
    endtask

    task automatic send_one(input int i, input logic [8:0] w);
        int t;
        t = 0;
        @(negedge sysclk);
        data_v[i]  = w;
        valid_v[i] = 1'b1;
        while (rdy_v[i] !== 1'b1 && t < 300) begin
            t++;
            @(negedge sysclk);
        end
        if (t >= 300) check($sformatf("i%0d accept_timeout", i), 0, 1);
        @(negedge sysclk);
        valid_v[i] = 1'b0;
    endtask

    // Valid stays high across both words; data wanders while the block is not ready.
    task automatic send_pair(input int i, input logic [8:0] w0, input logic [8:0] w1);
        int t;
        t = 0;
        @(negedge sysclk);
        data_v[i]  = w0;
        valid_v[i] = 1'b1;
        while (rdy_v[i] !== 1'b1 && t < 300) begin
            t++;
            @(negedge sysclk);
        end
        @(negedge sysclk);
        while (rdy_v[i] !== 1'b1 && t < 600) begin
            data_v[i] = 9'($urandom);
            t++;
            @(negedge sysclk);
        end
        if (t >= 600) check($sformatf("i%0d pair_timeout", i), 0, 1);
        data_v[i] = w1;
        @(negedge sysclk);
        valid_v[i] = 1'b0;
    endtask

    task automatic run_single(input int i, input logic [8:0] w);
        sel = i;
        fork
            send_one(i, w);
            check_frames(i, 1, -1);
        join
    endtask

    task automatic run_pair(input int i, input logic [8:0] w0, input logic [8:0] w1);
        sel = i;
        fork
            send_pair(i, w0, w1);
            check_frames(i, 2, 1);
        join
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        sel     = 0;
        acc_t   = 0;
        rst     = 1'b1;
        valid_v = '0;
        for (int i = 0; i < int'(NI); i++) data_v[i] = '0;
`ifdef UART_TX_BREAK_EN
        brk_v = '0;
`endif
        #12;
        for (int i = 0; i < int'(NI); i++) begin
            check($sformatf("i%0d reset_state", i), {so_v[i], busy_v[i], rdy_v[i]}, 3'b101);
        end
        @(negedge sysclk);
        rst = 1'b0;

        run_single(0, 9'h041);
        run_single(1, 9'h041);
        run_single(2, 9'h041);
        run_single(3, 9'h055);
        run_single(4, 9'h1a5);
        run_pair(0, 9'h0a5, 9'h03c);
        run_pair(4, 9'h155, 9'h0aa);

        // Abort in the middle of data bit 3 (start occupies cycles 0-9, bit 3 cycles 40-49).
        sel = 0;
        send_one(0, 9'h041);
        repeat (45) @(negedge sysclk);
        check("pre_reset_line", so_v[0], 0);
        #2 rst = 1'b1;
        #1 check("reset_abort", {so_v[0], busy_v[0], rdy_v[0]}, 3'b101);
        exp_q.delete();
        @(negedge sysclk);
        rst = 1'b0;
        run_single(0, 9'h096);

`ifdef UART_TX_BREAK_EN
        begin
            int cnt;
            sel = 0;
            @(negedge sysclk);
            brk_v[0]   = 1'b1;
            data_v[0]  = 9'h041;
            valid_v[0] = 1'b1;
            cnt = 0;
            repeat (50) begin
                #1 if (so_v[0] === 1'b0 && rdy_v[0] === 1'b0 && busy_v[0] === 1'b0) cnt++;
                @(negedge sysclk);
            end
            check("break_low", cnt, 50);
            brk_v[0] = 1'b0;
            cnt = 0;
            repeat (10) begin
                #1 if (so_v[0] === 1'b1 && rdy_v[0] === 1'b0 && busy_v[0] === 1'b0) cnt++;
                @(negedge sysclk);
            end
            check("mark_after_break", cnt, 10);
            check("no_transfer_in_break", exp_q.size(), 0);
            #1 check("ready_after_mab", rdy_v[0], 1);
            fork
                check_frames(0, 1, -1);
                begin
                    @(negedge sysclk);
                    valid_v[0] = 1'b0;
                end
            join
        end
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
